// File: rtl/stage_pkg.sv
// stage_pkg: FSM states, datapath widths and unit scales shared by the burnout-velocity stages.
package stage_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, DIV, ACC, DONE} state_t;
  localparam int VEL_W  = 64;
  localparam int MASS_W = 32;
  localparam int UEFF_W = 48;
  localparam int NUM_W  = 80;
  localparam int STEP_W = 16;
  localparam longint unsigned NMPS_PER_MPS = 64'd1_000_000_000;
  localparam int unsigned     G_PER_KG     = 32'd1_000;
endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per cycle, div_done one cycle after the last bit.
module seq_divider
  import stage_pkg::*;
#(
  parameter int N_W = NUM_W,
  parameter int D_W = MASS_W,
  parameter int Q_W = UEFF_W
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           go,
  input  logic [N_W-1:0] num,
  input  logic [D_W-1:0] den,
  output logic           busy,
  output logic           div_done,
  output logic [Q_W-1:0] quot
);
  localparam int CW = $clog2(N_W + 1);
  logic [N_W-1:0] q;
  logic [D_W-1:0] r, d;
  logic [CW-1:0]  cnt;
  logic [D_W:0]   sh;
  logic           ge;
  always_comb begin
    sh = {r, q[N_W-1]};
    ge = sh >= {1'b0, d};
  end
  assign quot = q[Q_W-1:0];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q        <= '0;
      r        <= '0;
      d        <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      div_done <= 1'b0;
    end else begin
      div_done <= 1'b0;
      if (busy) begin
        r   <= ge ? D_W'(sh - {1'b0, d}) : sh[D_W-1:0];
        q   <= {q[N_W-2:0], ge};
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          busy     <= 1'b0;
          div_done <= 1'b1;
        end
      end else if (go) begin
        q    <= num;
        r    <= '0;
        d    <= den;
        cnt  <= CW'(N_W);
        busy <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/second_stage_burn.sv
// second_stage_burn: integrates the second-stage burn as dv = U_EFF*dm/m per propellant step.
// Define GRAVITY_LOSS_EN to subtract a saturating gravity loss each step.
module second_stage_burn
  import stage_pkg::*;
#(
  parameter logic [MASS_W-1:0] M0_G       = 32'd690_000_000,
  parameter logic [MASS_W-1:0] MP_G       = 32'd444_000_000,
  parameter logic [MASS_W-1:0] MDOT_G     = 32'd1_233_334,
  parameter logic [UEFF_W-1:0] U_EFF_NMPS = 48'd2_577_137_000_000
`ifdef GRAVITY_LOSS_EN
  , parameter logic [VEL_W-1:0] G_DT_NMPS = 64'd9_799_000_000
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [VEL_W-1:0]  v_in,
  output logic              busy,
  output logic              done,
  output logic [VEL_W-1:0]  v_out,
  output logic [STEP_W-1:0] steps
);
  if (MP_G >= M0_G) begin : g_mp_chk
    $error("MP_G must be below M0_G");
  end
  if (MDOT_G == '0) begin : g_mdot_chk
    $error("MDOT_G must be nonzero");
  end
  state_t state, state_nx;
  logic [VEL_W-1:0]  v_acc, sum, acc_nx;
  logic [MASS_W-1:0] m, rem, dm, dm_nx;
  logic [STEP_W-1:0] step_cnt;
  logic [NUM_W-1:0]  num;
  logic [UEFF_W-1:0] dv;
  logic              go, div_busy, div_done;
  always_comb begin
    dm_nx = rem < MDOT_G ? rem : MDOT_G;
    num   = NUM_W'(U_EFF_NMPS) * NUM_W'(dm_nx);
    go    = state == LOAD && rem != '0 && !div_busy;
    sum   = v_acc + VEL_W'(dv);
`ifdef GRAVITY_LOSS_EN
    acc_nx = sum >= G_DT_NMPS ? sum - G_DT_NMPS : '0;
`else
    acc_nx = sum;
`endif
  end
  seq_divider #(.N_W(NUM_W), .D_W(MASS_W), .Q_W(UEFF_W)) u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .go       (go),
    .num      (num),
    .den      (m),
    .busy     (div_busy),
    .div_done (div_done),
    .quot     (dv)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? LOAD : IDLE;
      LOAD:    state_nx = rem == '0 ? DONE : DIV;
      DIV:     state_nx = div_done ? ACC : DIV;
      ACC:     state_nx = LOAD;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  assign busy = state inside {LOAD, DIV, ACC};
  assign done = state == DONE;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      v_acc    <= '0;
      m        <= '0;
      rem      <= '0;
      dm       <= '0;
      step_cnt <= '0;
      v_out    <= '0;
      steps    <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          v_acc    <= v_in;
          m        <= M0_G;
          rem      <= MP_G;
          step_cnt <= '0;
        end
        LOAD: begin
          dm <= dm_nx;
          if (rem == '0) begin
            v_out <= v_acc;
            steps <= step_cnt;
          end
        end
        ACC: begin
          v_acc    <= acc_nx;
          m        <= m - dm;
          rem      <= rem - dm;
          step_cnt <= step_cnt + STEP_W'(step_cnt != '1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/second_stage_burn.md
Name: second_stage_burn

Overview:
Downstream neighbour of the first-stage burnout-velocity block. It takes the first-stage burnout velocity (64-bit, 1e-9 m/s units, i.e. nm/s) and integrates the second-stage burn in discrete mass-flow steps. Each step applies dv = U_EFF*dm/m. It reports the second-stage burnout velocity and the number of steps used. A sequential divider replaces the $ln used upstream, so the block is synthesizable.

Parameters:
M0_G, 690_000_000, stage mass at ignition in grams; 32-bit.
MP_G, 444_000_000, second-stage propellant in grams; elaboration $error unless MP_G < M0_G.
MDOT_G, 1_233_334, propellant burnt per step in grams; must be nonzero.
U_EFF_NMPS, 2_577_137_000_000, effective exhaust velocity (g*Isp) in nm/s; 48-bit.
G_DT_NMPS, 9_799_000_000, gravity loss per step in nm/s; used only with the optional feature.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request; sampled only in IDLE
v_in  in  64  first-stage burnout velocity, nm/s; captured on accepted start
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse; v_out and steps are valid from this cycle
v_out  out  64  burnout velocity, nm/s; held until the next accepted start
steps  out  16  number of burn steps executed

Behaviour:
- Reset (async, reset_n=0): state=IDLE; busy=0, done=0, v_out=0, steps=0; divider cleared. Reset mid-burn aborts the burn with no done pulse.
- IDLE: when start=1, capture v_in into v_acc. Set m=M0_G, rem=MP_G, steps=0. Go to LOAD.
- start while not IDLE: ignored, no queuing.
- LOAD:
  - If rem==0, go to DONE.
  - Otherwise dm=min(MDOT_G, rem). The last step is clamped to the remaining propellant.
  - num = U_EFF_NMPS*dm (80-bit). Launch the divider with num/m (32-bit denominator). Go to DIV.
- DIV: wait for div_done. The divider takes exactly 80 iterations plus 1 cycle to return the quotient, so each step costs 83 cycles (LOAD + 81 + ACC).
- Quotient width: dv < U_EFF because dm ≤ rem < m, so the quotient is truncated to 48 bits without loss. Division truncates toward zero.
- ACC: v_acc += dv (64-bit, wraps modulo 2^64; this cannot occur with in-range parameters). m -= dm, rem -= dm, steps += 1 (saturates at 16'hFFFF). Go to LOAD.
- DONE: v_out=v_acc and steps are registered. done=1 for this one cycle, busy=0. Return to IDLE.
- MP_G==0: IDLE→LOAD→DONE; v_out=v_in, steps=0, done 2 cycles after start.
- start in the same cycle as done: ignored, because the FSM is not yet in IDLE.
- Denominator is never 0: m ≥ M0_G−MP_G > 0.

Optional Feature:
GRAVITY_LOSS_EN:
- Defined: in ACC, v_acc = v_acc + dv − G_DT_NMPS, saturating at 0. This subtraction never underflows below zero.
- Undefined: there is no gravity term, G_DT_NMPS is unused, and no logic is generated for it.

Decomposition:
- Package stage_pkg holds:
  - state enum {IDLE, LOAD, DIV, ACC, DONE};
  - width constants VEL_W=64, MASS_W=32, UEFF_W=48, NUM_W=80, STEP_W=16;
  - the nm/s and gram unit-scale constants shared with the first-stage block.
- One sub-module, seq_divider: restoring, unsigned, NUM_W/MASS_W.
  - Inputs: clk, reset_n, go, num, den.
  - Outputs: busy, div_done pulse, quot.
  - go is ignored while busy.

Test Plan:
1. Small parameters M0_G=1000, MP_G=500, MDOT_G=100, U_EFF_NMPS=1_000_000, v_in=0, start → done with steps=5, v_out=645_634 (100000+111111+125000+142857+166666), done 2+5*83 cycles after start.
2. Same, but MP_G=450 → last step clamped to dm=50, m=600 → steps=5, v_out=562_301.
3. MP_G=0, v_in=123_456 → v_out=123_456, steps=0, done pulse 2 cycles after start, busy=1 for exactly 1 cycle.
4. Test 1 with start pulsed again at cycles 10 and 200 while busy → ignored; v_out=645_634 once, only one done pulse.
5. Test 1, reset_n low at cycle 150 then high, then start with v_in=1_000 → no done from the aborted run; outputs 0 during reset; then v_out=646_634, steps=5.
6. GRAVITY_LOSS_EN defined, test-2 parameters, G_DT_NMPS=10_000 → v_out=512_301. Separately G_DT_NMPS=200_000 → v_out=0 (saturation).
